// File: rtl/exec_datapath.sv
// exec_datapath: register file, add/sub ALU and forwarding writeback register for the reduced RISC-V core.
// Optional EXEC_RETIRE_COUNT_EN adds a 32-bit retire_count output counting committed writes.
module exec_datapath #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int A0_INDEX       = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [31:0]           instr,
   input  logic [DATA_WIDTH-1:0] ImmOp,
   input  logic                  RegWrite,
   input  logic                  ALUctrl,
   input  logic                  ALUsrc,
   output logic                  EQ,
   output logic [DATA_WIDTH-1:0] a0
`ifdef EXEC_RETIRE_COUNT_EN
   ,
   output logic [31:0]           retire_count
`endif
);
   localparam int NREG = 2**REG_ADDR_WIDTH;
   localparam logic [REG_ADDR_WIDTH-1:0] A0 = REG_ADDR_WIDTH'(A0_INDEX);

   logic [DATA_WIDTH-1:0]     r_rf [NREG];
   logic                      r_wb_valid;
   logic [REG_ADDR_WIDTH-1:0] r_wb_rd;
   logic [DATA_WIDTH-1:0]     r_wb_data;
   logic [DATA_WIDTH-1:0]     r_a0;

   logic [REG_ADDR_WIDTH-1:0] w_rd, w_rs1, w_rs2;
   logic [DATA_WIDTH-1:0]     w_rs1_val, w_rs2_val, w_op_a, w_op_b, w_alu;
   logic                      w_commit, w_capture;
   logic                      w_unused;

   assign w_rd     = instr[7 +: REG_ADDR_WIDTH];
   assign w_rs1    = instr[15 +: REG_ADDR_WIDTH];
   assign w_rs2    = instr[20 +: REG_ADDR_WIDTH];
   assign w_unused = ^{instr[31:25], instr[14:12], instr[6:0]};

   // x0 reads as zero; a pending wb entry forwards ahead of the regfile
   assign w_rs1_val = (w_rs1 == '0) ? '0 : (r_wb_valid && r_wb_rd == w_rs1) ? r_wb_data : r_rf[w_rs1];
   assign w_rs2_val = (w_rs2 == '0) ? '0 : (r_wb_valid && r_wb_rd == w_rs2) ? r_wb_data : r_rf[w_rs2];

   assign w_op_a    = w_rs1_val;
   assign w_op_b    = ALUsrc ? ImmOp : w_rs2_val;
   assign w_alu     = ALUctrl ? w_op_a - w_op_b : w_op_a + w_op_b;
   assign EQ        = w_op_a == w_op_b;
   assign w_commit  = r_wb_valid && r_wb_rd != '0;
   assign w_capture = en && RegWrite && w_rd != '0;
   assign a0        = r_a0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
         r_wb_valid <= 1'b0;
         r_wb_rd    <= '0;
         r_wb_data  <= '0;
         r_a0       <= '0;
      end else begin
         if (w_commit) r_rf[r_wb_rd] <= r_wb_data;
         if (w_commit && r_wb_rd == A0) r_a0 <= r_wb_data;
         r_wb_valid <= w_capture;
         if (w_capture) begin
            r_wb_rd   <= w_rd;
            r_wb_data <= w_alu;
         end
      end
   end

`ifdef EXEC_RETIRE_COUNT_EN
   logic [31:0] r_retire;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_retire <= '0;
      else if (w_commit) r_retire <= r_retire + 32'd1;
   end
   assign retire_count = r_retire;
`endif
endmodule

// File: tb/tb_exec_datapath.sv
// tb_exec_datapath: directed vector table plus hand sequences for reset and async reset mid-pipe.
module tb_exec_datapath;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic [31:0] instr = '0;
   logic [31:0] ImmOp = '0;
   logic        RegWrite = 1'b0;
   logic        ALUctrl = 1'b0;
   logic        ALUsrc = 1'b0;
   logic        EQ;
   logic [31:0] a0;
`ifdef EXEC_RETIRE_COUNT_EN
   logic [31:0] retire_count;
`endif

   int pass_cnt = 0;
   int total_cnt = 0;

   exec_datapath dut (
      .clk(clk), .rst(rst), .en(en), .instr(instr), .ImmOp(ImmOp),
      .RegWrite(RegWrite), .ALUctrl(ALUctrl), .ALUsrc(ALUsrc), .EQ(EQ), .a0(a0)
`ifdef EXEC_RETIRE_COUNT_EN
      , .retire_count(retire_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] imm;
      logic        rw, ctl, src, en, eq;
      logic [31:0] a0;
   } vec_t;

   vec_t tv [22];

   function automatic vec_t v(int rd, int rs1, int rs2, logic [31:0] imm, logic rw, logic ctl,
                              logic src, logic e, logic eq, logic [31:0] a);
      vec_t t;
      t.rd = 5'(rd); t.rs1 = 5'(rs1); t.rs2 = 5'(rs2); t.imm = imm;
      t.rw = rw; t.ctl = ctl; t.src = src; t.en = e; t.eq = eq; t.a0 = a;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic drive(input logic [4:0] rd, rs1, rs2, input logic [31:0] imm,
                        input logic rw, ctl, src, e);
      instr = {7'd0, rs2, rs1, 3'd0, rd, 7'h13};
      ImmOp = imm; RegWrite = rw; ALUctrl = ctl; ALUsrc = src; en = e;
   endtask

   initial begin
      int exp_rc;
      logic prev_cap;
      tv[0]  = v(10, 0, 0, 32'd5, 1, 0, 1, 1, 0, 32'd0);
      tv[1]  = v(10, 10, 0, 32'd3, 1, 0, 1, 1, 0, 32'd5);
      tv[2]  = v(0, 10, 0, 32'd8, 0, 0, 1, 1, 1, 32'd8);
      tv[3]  = v(0, 10, 0, 32'd8, 0, 0, 1, 1, 1, 32'd8);
      tv[4]  = v(0, 0, 0, 32'd7, 1, 0, 1, 1, 0, 32'd8);
      tv[5]  = v(0, 0, 0, 32'd0, 0, 1, 1, 1, 1, 32'd8);
      tv[6]  = v(1, 0, 0, 32'd4, 1, 0, 1, 1, 0, 32'd8);
      tv[7]  = v(2, 0, 0, 32'd4, 1, 0, 1, 1, 0, 32'd8);
      tv[8]  = v(0, 1, 2, 32'd0, 0, 1, 0, 1, 1, 32'd8);
      tv[9]  = v(2, 0, 0, 32'd9, 1, 0, 1, 1, 0, 32'd8);
      tv[10] = v(0, 1, 2, 32'd0, 0, 1, 0, 1, 0, 32'd8);
      tv[11] = v(10, 2, 1, 32'd0, 1, 1, 0, 1, 0, 32'd8);
      tv[12] = v(0, 10, 0, 32'd5, 0, 0, 1, 1, 1, 32'd5);
      tv[13] = v(10, 0, 0, 32'd1, 1, 1, 1, 1, 0, 32'd5);
      tv[14] = v(10, 10, 0, 32'd1, 1, 0, 1, 1, 0, 32'hFFFF_FFFF);
      tv[15] = v(0, 10, 0, 32'd0, 0, 0, 1, 1, 1, 32'd0);
      tv[16] = v(10, 0, 0, 32'd1, 1, 0, 1, 1, 0, 32'd0);
      tv[17] = v(10, 0, 0, 32'd7, 1, 0, 1, 0, 0, 32'd1);
      tv[18] = v(10, 0, 0, 32'd7, 1, 0, 1, 0, 0, 32'd1);
      tv[19] = v(10, 0, 0, 32'd7, 1, 0, 1, 0, 0, 32'd1);
      tv[20] = v(10, 0, 0, 32'd7, 1, 0, 1, 0, 0, 32'd1);
      tv[21] = v(0, 10, 0, 32'd1, 0, 0, 1, 0, 1, 32'd1);

      // reset held with random bus activity
      for (int c = 0; c < 3; c++) begin
         instr = $urandom; ImmOp = $urandom_range(0, 3); RegWrite = 1'($urandom);
         ALUctrl = 1'($urandom); ALUsrc = 1'($urandom); en = 1'($urandom);
         @(posedge clk); #1;
         chk("reset_a0", a0, 32'd0);
         chk("reset_eq", {31'd0, EQ}, {31'd0, ALUsrc ? (ImmOp == 0) : 1'b1});
      end
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      rst = 1'b1;
      for (int r = 0; r < 32; r++) begin
         @(posedge clk); #1;
         drive(0, 5'(r), 0, 32'd0, 0, 0, 1, 0);
         #1 chk($sformatf("reset_x%0d", r), {31'd0, EQ}, 32'd1);
      end
`ifdef EXEC_RETIRE_COUNT_EN
      chk("reset_retire", retire_count, 32'd0);
`endif

      @(posedge clk); #1;
      exp_rc = 0;
      prev_cap = 1'b0;
      for (int i = 0; i < 22; i++) begin
         drive(tv[i].rd, tv[i].rs1, tv[i].rs2, tv[i].imm, tv[i].rw, tv[i].ctl, tv[i].src, tv[i].en);
         #1 chk($sformatf("vec%0d_eq", i), {31'd0, EQ}, {31'd0, tv[i].eq});
         @(posedge clk); #1;
         chk($sformatf("vec%0d_a0", i), a0, tv[i].a0);
         if (prev_cap) exp_rc++;
         prev_cap = tv[i].en && tv[i].rw && tv[i].rd != 0;
      end
`ifdef EXEC_RETIRE_COUNT_EN
      chk("retire_count", retire_count, 32'(exp_rc));
`endif

      // async reset between edges while x10=0x55 sits in wb
      drive(10, 0, 0, 32'h55, 1, 0, 1, 1);
      @(posedge clk); #1;
      drive(0, 10, 0, 32'd0, 0, 0, 1, 0);
      #1 rst = 1'b0;
      #1 chk("mid_rst_a0", a0, 32'd0);
      #1 rst = 1'b1;
      #1 chk("mid_rst_fwd_x10", {31'd0, EQ}, 32'd1);
      @(posedge clk); #1;
      chk("post_rst_a0", a0, 32'd0);
      ImmOp = 32'h55;
      #1 chk("post_rst_x10_not55", {31'd0, EQ}, 32'd0);
`ifdef EXEC_RETIRE_COUNT_EN
      chk("post_rst_retire", retire_count, 32'd0);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
